// File: rtl/button_event_pkg.sv
// Shared constants for the button event queue: event code bits, register map
// and the layout of one FIFO entry.
package button_event_pkg;

    localparam int EVT_DAYNIGHT = 0;
    localparam int EVT_MODE     = 1;
    localparam int EVT_TRIP     = 2;
    localparam int EVT_SETTING  = 3;
    localparam int EVT_W        = 4;

    localparam int STAMP_W      = 16;
    localparam int ENTRY_W      = 20;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_HEAD   = 2'd1;
    localparam logic [1:0] REG_POP    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_EMPTY     = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_OVERFLOW  = 16;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_OVF_CLR = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [EVT_W-1:0]   code;
    } entry_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous DEPTH-entry FIFO of timestamped events with push, pop and flush.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module event_fifo
    import button_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   wdata,
    output entry_t                   rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     cnt;
    logic               do_push;
    logic               do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge HCLK) begin
        if (HRESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; an empty FIFO never exposes its contents.
    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/button_event_queue.sv
// AHB-Lite slave that timestamps button event pulses into a FIFO drained by
// firmware, with a level interrupt while entries are pending.
module button_event_queue
    import button_event_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 33
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        Evt_DayNight,
    input  logic        Evt_Mode,
    input  logic        Evt_Trip,
    input  logic        Evt_Setting,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        Irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]   presc;
    logic [STAMP_W-1:0] stamp;

    logic               ph_valid;
    logic               ph_write;
    logic [1:0]         ph_addr;

    logic               irq_en;
    logic               overflow;

    logic [EVT_W-1:0]   evt_code;
    logic               push_req;
    logic               wr_en;
    logic               rd_en;
    logic               ctrl_wr;
    logic               pop_req;
    logic               flush_req;
    logic               ovf_clr;
    logic               ovf_set;

    entry_t             push_entry;
    entry_t             head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    logic               unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:3]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            presc <= '0;
            stamp <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            stamp <= stamp + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ph_valid <= 1'b0;
            ph_write <= 1'b0;
            ph_addr  <= '0;
        end else begin
            ph_valid <= HSEL && HREADY && (HTRANS != 2'b00);
            ph_write <= HWRITE;
            ph_addr  <= HADDR[3:2];
        end
    end

    assign wr_en     = ph_valid && ph_write;
    assign rd_en     = ph_valid && !ph_write;
    assign ctrl_wr   = wr_en && (ph_addr == REG_CTRL);
    assign pop_req   = wr_en && (ph_addr == REG_POP);
    assign flush_req = ctrl_wr && HWDATA[CTRL_FLUSH];
    assign ovf_clr   = ctrl_wr && HWDATA[CTRL_OVF_CLR];

    assign evt_code = {Evt_Setting, Evt_Trip, Evt_Mode, Evt_DayNight};
    assign push_req = |evt_code;
    assign push_entry.stamp = stamp;
    assign push_entry.code  = evt_code;

    // A full FIFO always has a head, so a pop in the same cycle makes room.
    assign ovf_set = push_req && fifo_full && !pop_req && !flush_req;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= HWDATA[CTRL_IRQ_EN];
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .push   (push_req),
        .pop    (pop_req),
        .flush  (flush_req),
        .wdata  (push_entry),
        .rdata  (head),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_comb begin
        HRDATA = '0;
        if (rd_en) begin
            case (ph_addr)
                REG_STATUS: begin
                    HRDATA[CNT_W-1:0]   = fifo_count;
                    HRDATA[ST_EMPTY]    = fifo_empty;
                    HRDATA[ST_FULL]     = fifo_full;
                    HRDATA[ST_OVERFLOW] = overflow;
                end
                REG_HEAD: begin
                    if (!fifo_empty) begin
                        HRDATA[EVT_W-1:0] = head.code;
                        HRDATA[31:16]     = head.stamp;
                    end
                end
                REG_CTRL: HRDATA[CTRL_IRQ_EN] = irq_en;
                default:  HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign Irq       = irq_en && !fifo_empty;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: a queue-based model checked every
// cycle on two instances (normal prescaler and a one-cycle tick), plus literals.
module tb_button_event_queue;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 33;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic        HSEL = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [1:0]  HTRANS = 2'b00;
    logic [3:0]  evt = '0;

    logic [31:0] HRDATA, HRDATA_w;
    logic        HREADYOUT, HREADYOUT_w;
    logic        Irq, Irq_w;

    always #5 HCLK = ~HCLK;

    button_event_queue #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .Evt_DayNight(evt[0]), .Evt_Mode(evt[1]),
        .Evt_Trip(evt[2]), .Evt_Setting(evt[3]), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .Irq(Irq)
    );

    button_event_queue #(.DEPTH(DEPTH), .TICK_DIV(1)) dut_w (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .Evt_DayNight(evt[0]), .Evt_Mode(evt[1]),
        .Evt_Trip(evt[2]), .Evt_Setting(evt[3]), .HRDATA(HRDATA_w),
        .HREADYOUT(HREADYOUT_w), .Irq(Irq_w)
    );

    // Model: entries remember the cycle count since reset; each instance's
    // stamp is that count divided by its tick length.
    typedef struct {
        logic [3:0]  code;
        int unsigned t;
    } mentry_t;

    mentry_t     mq[$];
    logic        m_ovf = 1'b0;
    logic        m_irq_en = 1'b0;
    logic        m_ph_valid = 1'b0;
    logic        m_ph_write = 1'b0;
    logic [1:0]  m_ph_addr = '0;
    int unsigned cyc = 0;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] exp_rdata(int unsigned div);
        logic [31:0] r;
        r = '0;
        if (m_ph_valid && !m_ph_write) begin
            case (m_ph_addr)
                2'd0: begin
                    r[2:0] = 3'(mq.size());
                    r[8]   = (mq.size() == 0);
                    r[9]   = (mq.size() == DEPTH);
                    r[16]  = m_ovf;
                end
                2'd1: if (mq.size() != 0) begin
                    r[3:0]   = mq[0].code;
                    r[31:16] = 16'((mq[0].t / div) % 65536);
                end
                2'd3: r[0] = m_irq_en;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic void model_edge();
        logic    pop, flush, clr, ovf_set;
        mentry_t e;
        if (HRESET) begin
            mq.delete();
            m_ovf = 1'b0;
            m_irq_en = 1'b0;
            m_ph_valid = 1'b0;
            m_ph_write = 1'b0;
            m_ph_addr = '0;
            cyc = 0;
            return;
        end
        pop = 1'b0; flush = 1'b0; clr = 1'b0; ovf_set = 1'b0;
        if (m_ph_valid && m_ph_write) begin
            if (m_ph_addr == 2'd2) pop = 1'b1;
            if (m_ph_addr == 2'd3) begin
                m_irq_en = HWDATA[0];
                clr      = HWDATA[1];
                flush    = HWDATA[2];
            end
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (evt != 4'b0) begin
                if (mq.size() < DEPTH) begin
                    e.code = evt;
                    e.t    = cyc;
                    mq.push_back(e);
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        cyc++;
        m_ph_valid = HSEL && HREADY && (HTRANS != 2'b00);
        m_ph_write = HWRITE;
        m_ph_addr  = HADDR[3:2];
    endfunction

    function automatic void compare_outputs();
        logic exp_irq;
        exp_irq = m_irq_en && (mq.size() != 0);
        check("hrdata",      HRDATA,                  exp_rdata(TICK_DIV));
        check("hrdata_w",    HRDATA_w,                exp_rdata(1));
        check("irq",         {31'b0, Irq},            {31'b0, exp_irq});
        check("irq_w",       {31'b0, Irq_w},          {31'b0, exp_irq});
        check("hreadyout",   {31'b0, HREADYOUT},      32'd1);
        check("hreadyout_w", {31'b0, HREADYOUT_w},    32'd1);
    endfunction

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        @(negedge HCLK);
        compare_outputs();
        #1;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    endtask

    task automatic ahb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] ev);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'b0, a, 2'b00};
        tick();
        bus_idle();
        HWDATA = d;
        evt = ev;
        tick();
        HWDATA = '0;
        evt = '0;
    endtask

    task automatic ahb_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] dw);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'b0, a, 2'b00};
        tick();
        d  = HRDATA;
        dw = HRDATA_w;
        bus_idle();
        tick();
    endtask

    task automatic pulse(input logic [3:0] e);
        evt = e;
        tick();
        evt = '0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, dw;
        logic [3:0]  codes [4];
        codes[0] = 4'h1; codes[1] = 4'h2; codes[2] = 4'h4; codes[3] = 4'h8;

        bus_idle();
        HRESET = 1'b1;
        repeat (3) tick();
        HRESET = 1'b0;

        ahb_read(2'd0, d, dw);  check("reset_status", d, 32'h0000_0100);
        ahb_read(2'd1, d, dw);  check("reset_head", d, 32'h0);
        check("reset_irq", {31'b0, Irq}, 32'd0);

        ahb_write(2'd3, 32'd1, 4'b0);
        repeat (3 * TICK_DIV) tick();
        evt = 4'b0010;
        tick();
        evt = '0;
        check("irq_after_event", {31'b0, Irq}, 32'd1);
        ahb_read(2'd0, d, dw);  check("status_one", d, 32'h0000_0001);
        ahb_read(2'd1, d, dw);  check("head_mode", d, 32'h0003_0002);
        ahb_write(2'd2, 32'd0, 4'b0);
        ahb_read(2'd0, d, dw);  check("status_after_pop", d, 32'h0000_0100);
        check("irq_after_pop", {31'b0, Irq}, 32'd0);

        pulse(4'b0110);
        ahb_read(2'd0, d, dw);  check("combined_count", d, 32'h0000_0001);
        ahb_read(2'd1, d, dw);  check("combined_code", {28'b0, d[3:0]}, 32'h6);
        ahb_write(2'd2, 32'd0, 4'b0);

        for (int i = 0; i < 4; i++) pulse(codes[i]);
        pulse(4'b0001);
        ahb_read(2'd0, d, dw);  check("status_overflow", d, 32'h0001_0204);
        for (int i = 0; i < 4; i++) begin
            ahb_read(2'd1, d, dw);
            check("pop_order_code", {28'b0, d[3:0]}, {28'b0, codes[i]});
            ahb_write(2'd2, 32'd0, 4'b0);
        end
        ahb_read(2'd0, d, dw);  check("empty_ovf_kept", d, 32'h0001_0100);
        ahb_write(2'd3, 32'd2, 4'b0);
        ahb_read(2'd0, d, dw);  check("ovf_cleared", d, 32'h0000_0100);
        ahb_read(2'd3, d, dw);  check("ctrl_readback", d, 32'h0);
        ahb_write(2'd3, 32'd1, 4'b0);

        pulse(4'h8); pulse(4'h4); pulse(4'h2); pulse(4'h8);
        ahb_write(2'd2, 32'd0, 4'b0001);
        ahb_read(2'd0, d, dw);  check("full_pop_push", d, 32'h0000_0204);
        repeat (3) ahb_write(2'd2, 32'd0, 4'b0);
        ahb_read(2'd1, d, dw);  check("newest_code", {28'b0, d[3:0]}, 32'h1);
        ahb_write(2'd2, 32'd0, 4'b0);

        ahb_write(2'd2, 32'd0, 4'b0100);
        ahb_read(2'd0, d, dw);  check("empty_pop_push", d, 32'h0000_0001);
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h8;
        tick();
        bus_idle();
        tick();
        ahb_read(2'd0, d, dw);  check("idle_trans_ignored", d, 32'h0000_0001);
        ahb_write(2'd2, 32'd0, 4'b0);

        for (int i = 0; i < 4; i++) pulse(codes[i]);
        ahb_write(2'd3, 32'd3, 4'b0010);
        ahb_read(2'd0, d, dw);  check("ovf_set_wins", d, 32'h0001_0204);
        ahb_write(2'd3, 32'd5, 4'b0001);
        ahb_read(2'd0, d, dw);  check("flush_with_event", d, 32'h0001_0100);
        check("irq_after_flush", {31'b0, Irq}, 32'd0);
        ahb_write(2'd3, 32'd3, 4'b0);
        ahb_read(2'd0, d, dw);  check("ovf_clear2", d, 32'h0000_0100);

        pulse(4'h1); pulse(4'h2);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8;
        tick();
        bus_idle();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        ahb_read(2'd0, d, dw);  check("midop_reset_status", d, 32'h0000_0100);
        ahb_read(2'd3, d, dw);  check("midop_reset_ctrl", d, 32'h0);

        while (cyc < 65535) tick();
        evt = 4'h8;
        tick();
        evt = 4'h1;
        tick();
        evt = '0;
        ahb_read(2'd1, d, dw);
        check("stamp_ffff_w", dw, 32'hFFFF_0008);
        check("stamp_slow", d, 32'h07C1_0008);
        ahb_write(2'd2, 32'd0, 4'b0);
        ahb_read(2'd1, d, dw);
        check("stamp_wrap_w", dw, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
